stopwatch_core: RTL
===================

# stopwatch_core

Parametrised BCD stopwatch/countdown core for the seven-segment clock display path. Replaces the two-clock counter with a single-clock design driven by one-cycle enable strobes. Adds a configurable number of minute digits, a pause toggle, a field-selective adjust mode, up/down counting and an expiry state. Sits between the tick/strobe generator and the display multiplexer, which consumes its BCD digit outputs directly.

## Interface
- MIN_DIGITS, 2: number of BCD minute digits, legal range 1..4; minute maximum MAX_MIN = 10^MIN_DIGITS − 1.
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- tick_1hz  in  1  one-cycle enable strobe; advances the count by one second when running.
- tick_adj  in  1  one-cycle enable strobe; advances the selected field in adjust mode.
- pause  in  1  one-cycle pulse, debounced upstream; toggles run/pause.
- adjust  in  1  level; 1 = adjust mode.
- select  in  1  adjust field select: 0 = minutes, 1 = seconds.
- dir  in  1  0 = count up, 1 = count down.
- min_bcd  out  4*MIN_DIGITS  minute digits, least significant digit in [3:0].
- sec1  out  4  tens of seconds, 0..5.
- sec0  out  4  units of seconds, 0..9.
- running  out  1  high in state RUN.
- expired  out  1  high in state EXPIRED.
- wrap  out  1  one-cycle pulse on up-count rollover MAX_MIN:59 → 00:00.

## Operation
- States: RUN, PAUSE, ADJ, EXPIRED. A `resume` flag records whether to return to RUN or PAUSE on leaving ADJ.
- Reset: all digits 0, state RUN, resume=RUN, wrap=0, expired=0, running=1.
- Per-cycle priority: reset > adjust > pause > tick_1hz.
- adjust=1 from any state → ADJ.
  - Entering from RUN sets resume=RUN. Entering from PAUSE or EXPIRED sets resume=PAUSE.
  - In ADJ, tick_1hz and pause are ignored.
  - With select=1, tick_adj adds 1 to seconds, 59 → 00 with no carry into minutes.
  - With select=0, tick_adj adds 1 to minutes, MAX_MIN → 0. Seconds are held.
  - Adjust always increments, regardless of dir.
- adjust falling → state = resume on the next cycle.
- RUN:
  - pause → PAUSE. A tick_1hz in the same cycle is discarded.
  - tick_1hz with dir=0: BCD +1 s. sec0 9 → 0 carries into sec1; sec1:sec0 59 → 00 carries into minutes; minute digits ripple BCD. MAX_MIN:59 → 00:00 and pulse wrap.
  - tick_1hz with dir=1: BCD −1 s with borrow, 00 s → 59 s and minutes −1.
    - A tick that yields 00:00 keeps state RUN.
    - A tick while the value is 00:00 enters EXPIRED; the value is unchanged.
- PAUSE: the value is held. pause → RUN. tick_1hz is ignored.
- EXPIRED: the value is held and pause is ignored. dir=0 → PAUSE. adjust → ADJ. reset → RUN.
- All digits remain legal BCD at all times. Arithmetic is per-digit 4-bit with explicit carry/borrow; no binary-to-BCD conversion.

## Timing
- All outputs are registered and change only on posedge clk.
- Tick latency: digits reflect a tick_1hz or tick_adj one cycle after the strobe cycle.
- wrap is asserted in the same cycle that the digits show 00:00 and lasts exactly one cycle.
- running and expired update in the same cycle as the state register; a 1-cycle pause pulse makes running fall on the next edge.
- Adjacent-cycle ticks each take effect; there is no minimum tick spacing.
- Reset mid-count or mid-adjust takes effect on the next edge. In that cycle all strobes are ignored.
- Changing dir takes effect at the next tick. The only exception is the EXPIRED exit, which occurs on the cycle dir=0 is sampled.

## Test plan
- Reset, then 61 tick_1hz (dir=0) → digits 01:01, running=1, wrap never asserted.
- MIN_DIGITS=2: adjust select=0 with 99 tick_adj, then select=1 with 59 tick_adj, release adjust, 1 tick_1hz → 00:00 with a one-cycle wrap; minutes 99 confirmed before the tick.
- dir=1 from 00:02: tick, tick, tick → 00:01, 00:00 (running=1), then hold at 00:00 with expired=1. A further tick and a pause pulse change nothing. dir=0 → running=0, expired=0.
- pause and tick_1hz in the same cycle at 00:10 → value stays 00:10, running=0. Second pause → running=1, next tick → 00:11.
- Paused at 05:30, adjust select=1, 35 tick_adj → 05:05 with minutes unchanged. Release adjust → state PAUSE.
- Reset asserted mid-run at 12:34 with a coincident tick_1hz → next cycle 00:00, running=1. MIN_DIGITS=1 and 4 rerun the rollover at 9:59 and 9999:59.

Source files
------------

// File: rtl/stopwatch_core.sv
// BCD stopwatch/countdown with pause, field-selective adjust, up/down count and expiry.
// Single clock; all outputs registered; strobes act one cycle after they are sampled.
module stopwatch_core #(
    parameter int MIN_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_1hz,
    input  logic                    tick_adj,
    input  logic                    pause,
    input  logic                    adjust,
    input  logic                    select,
    input  logic                    dir,
    output logic [4*MIN_DIGITS-1:0] min_bcd,
    output logic [3:0]              sec1,
    output logic [3:0]              sec0,
    output logic                    running,
    output logic                    expired,
    output logic                    wrap
);

    typedef enum logic [1:0] {S_RUN, S_PAUSE, S_ADJ, S_EXPIRED} state_t;

    state_t state;
    logic   resume_run;

    logic [4*MIN_DIGITS-1:0] min_inc;
    logic [4*MIN_DIGITS-1:0] min_dec;
    logic                    min_max;
    logic                    min_zero;
    logic [3:0]              sec0_inc, sec1_inc, sec0_dec, sec1_dec;
    logic                    sec_carry, sec_borrow;

    // Minute digits ripple with explicit per-digit carry and borrow.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] d;
        min_inc  = min_bcd;
        min_dec  = min_bcd;
        min_max  = 1'b1;
        min_zero = 1'b1;
        carry    = 1'b1;
        borrow   = 1'b1;
        d        = 4'd0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            d = min_bcd[4*i +: 4];
            if (d != 4'd9) min_max = 1'b0;
            if (d != 4'd0) min_zero = 1'b0;
            if (carry) begin
                if (d == 4'd9) begin
                    min_inc[4*i +: 4] = 4'd0;
                end else begin
                    min_inc[4*i +: 4] = d + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (d == 4'd0) begin
                    min_dec[4*i +: 4] = 4'd9;
                end else begin
                    min_dec[4*i +: 4] = d - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    assign sec_carry  = (sec1 == 4'd5) && (sec0 == 4'd9);
    assign sec_borrow = (sec1 == 4'd0) && (sec0 == 4'd0);
    assign sec0_inc   = (sec0 == 4'd9) ? 4'd0 : sec0 + 4'd1;
    assign sec1_inc   = (sec0 != 4'd9) ? sec1 : ((sec1 == 4'd5) ? 4'd0 : sec1 + 4'd1);
    assign sec0_dec   = (sec0 == 4'd0) ? 4'd9 : sec0 - 4'd1;
    assign sec1_dec   = (sec0 != 4'd0) ? sec1 : ((sec1 == 4'd0) ? 4'd5 : sec1 - 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RUN;
            resume_run <= 1'b1;
            min_bcd    <= '0;
            sec1       <= 4'd0;
            sec0       <= 4'd0;
            running    <= 1'b1;
            expired    <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (adjust) begin
                state   <= S_ADJ;
                running <= 1'b0;
                expired <= 1'b0;
                if (state != S_ADJ) resume_run <= (state == S_RUN);
                // Adjust always counts up; seconds never carry into minutes.
                if (tick_adj) begin
                    if (select) begin
                        sec1 <= sec1_inc;
                        sec0 <= sec0_inc;
                    end else begin
                        min_bcd <= min_inc;
                    end
                end
            end else begin
                case (state)
                    S_ADJ: begin
                        state   <= resume_run ? S_RUN : S_PAUSE;
                        running <= resume_run;
                    end
                    S_RUN: begin
                        if (pause) begin
                            state   <= S_PAUSE;
                            running <= 1'b0;
                        end else if (tick_1hz) begin
                            if (!dir) begin
                                sec1 <= sec1_inc;
                                sec0 <= sec0_inc;
                                if (sec_carry) min_bcd <= min_inc;
                                wrap <= sec_carry && min_max;
                            end else if (sec_borrow && min_zero) begin
                                state   <= S_EXPIRED;
                                running <= 1'b0;
                                expired <= 1'b1;
                            end else begin
                                sec1 <= sec1_dec;
                                sec0 <= sec0_dec;
                                if (sec_borrow) min_bcd <= min_dec;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (pause) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_EXPIRED: begin
                        if (!dir) begin
                            state   <= S_PAUSE;
                            expired <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        expired <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
